// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared types and defaults for the forwarding/hazard controller.
// Scoreboard entry layout, writeback-source encoding and readiness helpers.
package hazard_forward_ctrl_pkg;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wbsel_t;

    localparam int DEF_NSRC    = 3;
    localparam int DEF_NSTAGE  = 3;
    localparam int DEF_ALU_RDY = 1;
    localparam int DEF_LD_RDY  = 2;
    localparam int FWD_REGFILE = 0;

    typedef logic [$clog2(DEF_NSTAGE)-1:0] fwd_sel_t;

    typedef struct packed {
        logic   valid;
        logic   regwen;
        wbsel_t wbsel;
        logic [4:0] rd;
    } sb_entry_t;

    localparam sb_entry_t BUBBLE = '0;

    // x0 writes are architecturally discarded, so they never create a dependency.
    function automatic logic is_live(sb_entry_t e);
        return e.valid && e.regwen && (e.rd != 5'd0);
    endfunction

    function automatic int ready_stage(wbsel_t wbsel, int alu_rdy, int ld_rdy);
        return (wbsel == WB_MEM) ? ld_rdy : alu_rdy;
    endfunction

endpackage

// File: rtl/hazard_forward_ctrl_if.sv
// ID-stage bundle between the decode stage (master) and the hazard controller (slave).
// id_valid qualifies all id_* fields; an ID instruction is consumed on a clock where
// id_valid & !hazard_stall & !pipe_hold & !flush_id, otherwise ID must present it again.
interface hazard_forward_ctrl_if
    import hazard_forward_ctrl_pkg::*;
#(
    parameter int NSRC   = DEF_NSRC,
    parameter int NSTAGE = DEF_NSTAGE
) ();
    localparam int FW = $clog2(NSTAGE);

    logic               id_valid;
    logic               id_regwen;
    wbsel_t             id_wbsel;
    logic [4:0]         id_rd;
    logic [NSRC*5-1:0]  id_rs;
    logic [NSRC-1:0]    id_rs_used;
    logic               flush_id;
    logic               pipe_hold;
    logic               hazard_stall;
    logic [NSRC*FW-1:0] fwd_sel_ex;

    modport master (
        output id_valid, id_regwen, id_wbsel, id_rd, id_rs, id_rs_used, flush_id, pipe_hold,
        input  hazard_stall, fwd_sel_ex
    );

    modport slave (
        input  id_valid, id_regwen, id_wbsel, id_rd, id_rs, id_rs_used, flush_id, pipe_hold,
        output hazard_stall, fwd_sel_ex
    );
endinterface

// File: rtl/hazard_forward_ctrl_fwd_src_match.sv
// Priority match of one source operand against the in-flight writer scoreboard.
// Produces the forward select the operand needs in EX, or a stall when not yet ready.
module hazard_forward_ctrl_fwd_src_match
    import hazard_forward_ctrl_pkg::*;
#(
    parameter int NSTAGE  = DEF_NSTAGE,
    parameter int ALU_RDY = DEF_ALU_RDY,
    parameter int LD_RDY  = DEF_LD_RDY,
    parameter int FW      = $clog2(DEF_NSTAGE)
) (
    input  logic                   req_i,
    input  logic [4:0]             rs_i,
    input  sb_entry_t [NSTAGE-1:0] sb_i,
    output logic [FW-1:0]          sel_o,
    output logic                   stall_o
);
    logic found;

    // Entry j sits at stage j+1 once the consumer enters EX; the first hit is the
    // youngest writer and masks every older one, even if that one is not ready.
    always_comb begin
        sel_o   = FW'(FWD_REGFILE);
        stall_o = 1'b0;
        found   = 1'b0;
        for (int j = 0; j < NSTAGE; j++) begin
            if (req_i && !found && is_live(sb_i[j]) && (sb_i[j].rd == rs_i)) begin
                found = 1'b1;
                if (j + 1 < NSTAGE) begin
                    if (j + 1 >= ready_stage(sb_i[j].wbsel, ALU_RDY, LD_RDY)) begin
                        sel_o = FW'(j + 1);
                    end else begin
                        stall_o = 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: rtl/hazard_forward_ctrl.sv
// Forwarding/hazard controller: shift scoreboard of in-flight writers, registered EX selects
// and load-use stall. Optional perf counters are built when FWD_PERF_EN is defined.
module hazard_forward_ctrl
    import hazard_forward_ctrl_pkg::*;
#(
    parameter int NSRC    = DEF_NSRC,
    parameter int NSTAGE  = DEF_NSTAGE,
    parameter int ALU_RDY = DEF_ALU_RDY,
    parameter int LD_RDY  = DEF_LD_RDY
) (
    input  logic                    clk,
    input  logic                    rst,
    hazard_forward_ctrl_if.slave    bus,
    output logic [31:0]             perf_stall_cnt,
    output logic [31:0]             perf_fwd_cnt
);
    localparam int FW = $clog2(NSTAGE);

    sb_entry_t [NSTAGE-1:0]   sb_q, sb_d;
    logic [NSRC-1:0][FW-1:0]  sel_q, sel_d, sel_cmb;
    logic [NSRC-1:0]          op_stall;
    logic                     stall_raw;
    logic                     advance;
    sb_entry_t                id_entry;

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        hazard_forward_ctrl_fwd_src_match #(
            .NSTAGE  (NSTAGE),
            .ALU_RDY (ALU_RDY),
            .LD_RDY  (LD_RDY),
            .FW      (FW)
        ) u_match (
            .req_i   (bus.id_valid && bus.id_rs_used[i] && (bus.id_rs[5*i +: 5] != 5'd0)),
            .rs_i    (bus.id_rs[5*i +: 5]),
            .sb_i    (sb_q),
            .sel_o   (sel_cmb[i]),
            .stall_o (op_stall[i])
        );
    end

    assign id_entry = '{valid: bus.id_valid, regwen: bus.id_regwen,
                        wbsel: bus.id_wbsel, rd: bus.id_rd};

    assign stall_raw        = |op_stall;
    assign bus.hazard_stall = stall_raw && !bus.flush_id && !bus.pipe_hold;
    assign advance          = !bus.pipe_hold && !bus.flush_id && !stall_raw;

    // Flush and stall both bubble EX but still retire the older stages.
    always_comb begin
        sb_d  = sb_q;
        sel_d = sel_q;
        if (!bus.pipe_hold) begin
            sb_d  = {sb_q[NSTAGE-2:0], advance ? id_entry : BUBBLE};
            sel_d = advance ? sel_cmb : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_q  <= '0;
            sel_q <= '0;
        end else begin
            sb_q  <= sb_d;
            sel_q <= sel_d;
        end
    end

    assign bus.fwd_sel_ex = sel_q;

`ifdef FWD_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] fwd_cnt_q, fwd_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + {31'd0, bus.hazard_stall};
        fwd_cnt_d   = fwd_cnt_q + {31'd0, (advance && (|sel_cmb))};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_fwd_cnt   = fwd_cnt_q;
`else
    assign perf_stall_cnt = 32'd0;
    assign perf_fwd_cnt   = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Scoreboard bench for hazard_forward_ctrl: directed pipeline scenarios, then random ID traffic,
// checked against a history-queue model of the in-flight writers.
module tb_hazard_forward_ctrl;
    import hazard_forward_ctrl_pkg::*;

    localparam int NSRC    = 3;
    localparam int NSTAGE  = 3;
    localparam int FW      = 2;
    localparam int ALU_RDY = 1;
    localparam int LD_RDY  = 2;
    localparam int W       = 64 + NSRC*FW;

    logic        clk;
    logic        rst;
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_fwd_cnt;

    hazard_forward_ctrl_if #(.NSRC(NSRC), .NSTAGE(NSTAGE)) bus ();

    hazard_forward_ctrl #(
        .NSRC(NSRC), .NSTAGE(NSTAGE), .ALU_RDY(ALU_RDY), .LD_RDY(LD_RDY)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_fwd_cnt   (perf_fwd_cnt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        bit         valid;
        bit         regwen;
        wbsel_t     wbsel;
        logic [4:0] rd;
    } writer_t;

    writer_t                 hist[$];   // front = instruction that entered EX most recently
    logic [NSRC-1:0][FW-1:0] m_sel;
    logic [31:0]             m_stall_cnt;
    logic [31:0]             m_fwd_cnt;

    logic             exp_stall_q[$];
    logic [W-1:0]     exp_q[$];
    int               checks = 0;
    int               errors = 0;
    bit               mon_en = 1'b0;

    function automatic writer_t bubble_w();
        writer_t w;
        w.valid = 1'b0; w.regwen = 1'b0; w.wbsel = WB_ALU; w.rd = 5'd0;
        return w;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int d = 0; d < NSTAGE; d++) hist.push_back(bubble_w());
        m_sel       = '0;
        m_stall_cnt = 32'd0;
        m_fwd_cnt   = 32'd0;
    endtask

    function automatic logic [W-1:0] exp_state();
        logic [63:0] cnts;
`ifdef FWD_PERF_EN
        cnts = {m_stall_cnt, m_fwd_cnt};
`else
        cnts = 64'd0;
`endif
        return {cnts, m_sel};
    endfunction

    // ---------------- driver ----------------
    task automatic step(input bit r, input bit v, input bit we, input wbsel_t wb,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rs3, input logic [2:0] used, input bit fl, input bit hd);
        logic [4:0]              rsv [NSRC];
        logic [NSRC-1:0][FW-1:0] sel;
        bit                      any;
        int                      stage;
        int                      need;
        writer_t                 w;

        rst = r;
        bus.id_valid   = v;
        bus.id_regwen  = we;
        bus.id_wbsel   = wb;
        bus.id_rd      = rd;
        bus.id_rs      = {rs3, rs2, rs1};
        bus.id_rs_used = used;
        bus.flush_id   = fl;
        bus.pipe_hold  = hd;

        rsv[0] = rs1; rsv[1] = rs2; rsv[2] = rs3;
        sel = '0;
        any = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (v && used[i] && rsv[i] != 5'd0) begin
                for (int d = 0; d < NSTAGE; d++) begin
                    if (hist[d].valid && hist[d].regwen && hist[d].rd != 5'd0 && hist[d].rd == rsv[i]) begin
                        stage = d + 1;
                        need  = (hist[d].wbsel == WB_MEM) ? LD_RDY : ALU_RDY;
                        if (stage < NSTAGE) begin
                            if (stage >= need) sel[i] = FW'(stage);
                            else               any = 1'b1;
                        end
                        break;
                    end
                end
            end
        end
        exp_stall_q.push_back(any && !fl && !hd);

        if (r) begin
            model_reset();
        end else if (!hd) begin
            if (any && !fl) m_stall_cnt = m_stall_cnt + 32'd1;
            if (fl || any) begin
                hist.push_front(bubble_w());
                m_sel = '0;
            end else begin
                w.valid = v; w.regwen = we; w.wbsel = wb; w.rd = rd;
                hist.push_front(w);
                m_sel = sel;
                if (sel != '0) m_fwd_cnt = m_fwd_cnt + 32'd1;
            end
            void'(hist.pop_back());
        end
        exp_q.push_back(exp_state());

        @(posedge clk);
        #1;
    endtask

    task automatic op(input bit we, input wbsel_t wb, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rs3,
                      input logic [2:0] used);
        step(1'b0, 1'b1, we, wb, rd, rs1, rs2, rs3, used, 1'b0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, WB_ALU, 5'd0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 1'b0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic         e_stall;
        logic [W-1:0] e_state;
        logic [W-1:0] got;
        if (mon_en) begin
            if (exp_stall_q.size() > 0) begin
                e_stall = exp_stall_q.pop_front();
                checks++;
                if (bus.hazard_stall !== e_stall) begin
                    errors++;
                    $display("FAIL hazard_stall t=%0t got %0b want %0b", $time, bus.hazard_stall, e_stall);
                end
            end
            if (exp_q.size() > 0) begin
                e_state = exp_q.pop_front();
                got = {perf_stall_cnt, perf_fwd_cnt, bus.fwd_sel_ex};
                checks++;
                if (got !== e_state) begin
                    errors++;
                    $display("FAIL fwd_sel_ex/perf t=%0t got sel=%h stall_cnt=%0d fwd_cnt=%0d want sel=%h stall_cnt=%0d fwd_cnt=%0d",
                             $time, got[NSRC*FW-1:0], got[W-1:W-32], got[W-33:NSRC*FW],
                             e_state[NSRC*FW-1:0], e_state[W-1:W-32], e_state[W-33:NSRC*FW]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        bus.id_valid = 1'b0; bus.id_regwen = 1'b0; bus.id_wbsel = WB_ALU; bus.id_rd = 5'd0;
        bus.id_rs = '0; bus.id_rs_used = '0; bus.flush_id = 1'b0; bus.pipe_hold = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        exp_q.push_back(exp_state());
        mon_en = 1'b1;

        // add x5 ; add x6,x5,x1 -> rs1 from MEM
        op(1, WB_ALU, 5'd5, 5'd1, 5'd2, 5'd0, 3'b011);
        op(1, WB_ALU, 5'd6, 5'd5, 5'd1, 5'd0, 3'b011);
        idle();

        // lw x6 ; sw rs2=x6 -> one stall, then sel 2
        op(1, WB_MEM, 5'd6, 5'd1, 5'd0, 5'd0, 3'b001);
        op(0, WB_ALU, 5'd0, 5'd2, 5'd6, 5'd0, 3'b011);
        op(0, WB_ALU, 5'd0, 5'd2, 5'd6, 5'd0, 3'b011);
        idle();

        // two writers of x7, use as rs3 -> youngest (MEM)
        op(1, WB_ALU, 5'd7, 5'd1, 5'd0, 5'd0, 3'b001);
        op(1, WB_ALU, 5'd7, 5'd7, 5'd0, 5'd0, 3'b001);
        op(1, WB_ALU, 5'd9, 5'd1, 5'd2, 5'd7, 3'b111);
        idle();

        // rd=x0 producer, regwen=0 producer, rs=x0 consumer
        op(1, WB_ALU, 5'd0, 5'd1, 5'd0, 5'd0, 3'b001);
        op(0, WB_ALU, 5'd9, 5'd1, 5'd0, 5'd0, 3'b001);
        op(1, WB_ALU, 5'd10, 5'd0, 5'd9, 5'd0, 3'b011);
        idle();

        // lw x8 ; consumer flushed in its stall cycle
        op(1, WB_MEM, 5'd8, 5'd1, 5'd0, 5'd0, 3'b001);
        step(0, 1, 1, WB_ALU, 5'd11, 5'd8, 5'd0, 5'd0, 3'b001, 1, 0);
        idle();
        idle();

        // pipe_hold for 3 cycles with a pending load-use
        op(1, WB_ALU, 5'd12, 5'd1, 5'd0, 5'd0, 3'b001);
        op(1, WB_MEM, 5'd13, 5'd1, 5'd0, 5'd0, 3'b001);
        repeat (3) step(0, 1, 1, WB_ALU, 5'd14, 5'd12, 5'd13, 5'd0, 3'b011, 0, 1);
        op(1, WB_ALU, 5'd14, 5'd12, 5'd13, 5'd0, 3'b011);
        op(1, WB_ALU, 5'd14, 5'd12, 5'd13, 5'd0, 3'b011);
        idle();

        // distance boundaries: PC4 two ahead -> sel 2, load three ahead -> regfile
        op(1, WB_PC4, 5'd1, 5'd0, 5'd0, 5'd0, 3'b000);
        idle();
        op(1, WB_ALU, 5'd2, 5'd1, 5'd0, 5'd0, 3'b001);
        op(1, WB_MEM, 5'd3, 5'd1, 5'd0, 5'd0, 3'b001);
        idle();
        idle();
        op(1, WB_ALU, 5'd4, 5'd3, 5'd0, 5'd0, 3'b001);

        // reset mid-stream clears the scoreboard
        op(1, WB_MEM, 5'd14, 5'd1, 5'd0, 5'd0, 3'b001);
        op(1, WB_ALU, 5'd15, 5'd1, 5'd0, 5'd0, 3'b001);
        step(1, 1, 1, WB_ALU, 5'd16, 5'd14, 5'd15, 5'd0, 3'b011, 0, 0);
        op(1, WB_ALU, 5'd16, 5'd14, 5'd15, 5'd0, 3'b011);
        idle();

        // random traffic on a small register window to provoke hazards
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 63) == 0,
                 $urandom_range(0, 7) != 0,
                 $urandom_range(0, 3) != 0,
                 wbsel_t'($urandom_range(0, 2)),
                 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)),
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 7) == 0);
        end
        idle();

        @(negedge clk);
        #1;
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
